// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: RV32I load/store funct3 encodings and
// the MEM-stage FSM state type.
// Imported by the lsu_align datapath and by the mem_stage top.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ready port between the MEM stage and data memory.
// master: stage side (drives req/we/addr/wdata/be, receives ready/rdata).
// slave : memory side (the mirror image).
interface mem_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata
  );

endinterface

// File: rtl/mem_stage_lsu_align.sv
// Purely combinational load/store alignment: store byte-lane replication and
// byte enables, access legality (funct3 and alignment), load lane extraction
// with sign/zero extension. Ports: i_addr/i_sdata/i_funct3/i_is_store in,
// o_be/o_wdata/o_illegal out; i_ld_off/i_ld_funct3/i_rdata in, o_ldata out.
module lsu_align
  import mem_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic [31:0] i_sdata,
  input  logic [2:0]  i_funct3,
  input  logic        i_is_store,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_illegal,
  input  logic [1:0]  i_ld_off,
  input  logic [2:0]  i_ld_funct3,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ldata
);

  logic        w_bad_f3;
  logic        w_misal;
  logic [31:0] w_bsh;
  logic [31:0] w_hsh;

  always_comb begin
    o_be     = 4'b1111;
    o_wdata  = i_sdata;
    w_bad_f3 = 1'b0;
    if (i_is_store) begin
      case (i_funct3)
        F3_B: begin
          o_be    = 4'b0001 << i_addr[1:0];
          o_wdata = {4{i_sdata[7:0]}};
        end
        F3_H: begin
          o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_sdata[15:0]}};
        end
        F3_W:    w_bad_f3 = 1'b0;
        default: w_bad_f3 = 1'b1;
      endcase
    end else begin
      case (i_funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: w_bad_f3 = 1'b0;
        default:                        w_bad_f3 = 1'b1;
      endcase
    end
    // funct3[1:0] encodes the size for every legal load/store.
    w_misal   = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    o_illegal = w_bad_f3 | w_misal;
  end

  // Shift the addressed lane down to bit 0, then extend.
  always_comb begin
    w_bsh = i_rdata >> {i_ld_off, 3'b000};
    w_hsh = i_rdata >> {i_ld_off[1], 4'b0000};
    case (i_ld_funct3)
      F3_B:    o_ldata = {{24{w_bsh[7]}}, w_bsh[7:0]};
      F3_H:    o_ldata = {{16{w_hsh[15]}}, w_hsh[15:0]};
      F3_BU:   o_ldata = {24'd0, w_bsh[7:0]};
      F3_HU:   o_ldata = {16'd0, w_hsh[15:0]};
      default: o_ldata = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: takes the EX/MEM slot, runs loads/stores over a req/ready
// data port, and emits a one-cycle registered result strobe toward MEM/WB.
// Ports: clk/reset; i_* EX/MEM slot; dmem (mem_stage_if.master);
// o_stall_out upstream hold; o_wb_* writeback result; o_mem_fault pulse.
module mem_stage
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_in_valid,
  input  logic [31:0]  i_alu_result,
  input  logic [31:0]  i_store_data,
  input  logic [4:0]   i_rd_in,
  input  logic         i_reg_wen_in,
  input  logic         i_mem_wen_in,
  input  logic         i_mem_ren_in,
  input  logic [2:0]   i_funct3,
  mem_stage_if.master  dmem,
  output logic         o_stall_out,
  output logic         o_wb_valid,
  output logic [4:0]   o_wb_rd,
  output logic [31:0]  o_wb_data,
  output logic         o_wb_reg_wen,
  output logic         o_mem_fault
);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  logic        r_reg_wen;
  logic        r_stall;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_wb_reg_wen;
  logic        r_fault;

  logic        w_mem_op;
  logic        w_illegal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  assign w_mem_op = i_mem_wen_in | i_mem_ren_in;

  lsu_align u_align (
    .i_addr      (i_alu_result),
    .i_sdata     (i_store_data),
    .i_funct3    (i_funct3),
    .i_is_store  (i_mem_wen_in),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_illegal   (w_illegal),
    .i_ld_off    (r_off),
    .i_ld_funct3 (r_f3),
    .i_rdata     (dmem.dmem_rdata),
    .o_ldata     (w_ldata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= 8'd0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_be         <= 4'd0;
      r_off        <= 2'd0;
      r_f3         <= 3'd0;
      r_rd         <= 5'd0;
      r_reg_wen    <= 1'b0;
      r_stall      <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= 5'd0;
      r_wb_data    <= 32'd0;
      r_wb_reg_wen <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_fault    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_in_valid && !w_mem_op) begin
            r_wb_valid   <= 1'b1;
            r_wb_data    <= i_alu_result;
            r_wb_rd      <= i_rd_in;
            r_wb_reg_wen <= i_reg_wen_in;
          end else if (i_in_valid && w_illegal) begin
            r_wb_valid   <= 1'b1;
            r_wb_data    <= 32'd0;
            r_wb_rd      <= i_rd_in;
            r_wb_reg_wen <= 1'b0;
            r_fault      <= 1'b1;
          end else if (i_in_valid) begin
            r_state   <= BUSY;
            r_cnt     <= 8'd0;
            r_req     <= 1'b1;
            r_stall   <= 1'b1;
            r_we      <= i_mem_wen_in;
            r_addr    <= {i_alu_result[31:2], 2'b00};
            r_wdata   <= w_wdata;
            r_be      <= i_mem_wen_in ? w_be : 4'b1111;
            r_off     <= i_alu_result[1:0];
            r_f3      <= i_funct3;
            r_rd      <= i_rd_in;
            r_reg_wen <= i_reg_wen_in;
          end
        end
        BUSY: begin
          if (dmem.dmem_ready) begin
            r_state      <= IDLE;
            r_req        <= 1'b0;
            r_stall      <= 1'b0;
            r_wb_valid   <= 1'b1;
            r_wb_rd      <= r_rd;
            r_wb_reg_wen <= r_we ? 1'b0 : r_reg_wen;
            r_wb_data    <= r_we ? 32'd0 : w_ldata;
          end else if (r_cnt == 8'(MAX_WAIT - 1)) begin
            // Memory never answered: abandon the access and flag it.
            r_state      <= IDLE;
            r_req        <= 1'b0;
            r_stall      <= 1'b0;
            r_wb_valid   <= 1'b1;
            r_wb_rd      <= r_rd;
            r_wb_reg_wen <= 1'b0;
            r_wb_data    <= 32'd0;
            r_fault      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;
  assign dmem.dmem_be    = r_be;
  assign o_stall_out     = r_stall;
  assign o_wb_valid      = r_wb_valid;
  assign o_wb_rd         = r_wb_rd;
  assign o_wb_data       = r_wb_data;
  assign o_wb_reg_wen    = r_wb_reg_wen;
  assign o_mem_fault     = r_fault;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level model.
// Latency: one cycle per op for ALU/illegal, capture plus request cycles for memory ops.
// Backpressure: memory readiness is delayed per op, including delays that time out.
module tb_mem_stage;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd_in = '0;
  logic        reg_wen_in = 1'b0;
  logic        mem_wen_in = 1'b0;
  logic        mem_ren_in = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        stall_out, wb_valid, wb_reg_wen, mem_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_data = '0;
  bit          data_known = 1'b1;

  mem_stage_if u_if ();

  initial begin
    u_if.dmem_ready = 1'b0;
    u_if.dmem_rdata = '0;
  end

  mem_stage #(.MAX_WAIT(MAXW)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_in_valid   (in_valid),
    .i_alu_result (alu_result),
    .i_store_data (store_data),
    .i_rd_in      (rd_in),
    .i_reg_wen_in (reg_wen_in),
    .i_mem_wen_in (mem_wen_in),
    .i_mem_ren_in (mem_ren_in),
    .i_funct3     (funct3),
    .dmem         (u_if),
    .o_stall_out  (stall_out),
    .o_wb_valid   (wb_valid),
    .o_wb_rd      (wb_rd),
    .o_wb_data    (wb_data),
    .o_wb_reg_wen (wb_reg_wen),
    .o_mem_fault  (mem_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Access is legal when funct3 names a real access of that direction and
  // the address is a multiple of the access size.
  function automatic bit legal_ref(input bit w, input logic [2:0] f3, input logic [1:0] a);
    int size;
    if (w) begin
      if (f3 > 3'd2) return 1'b0;
    end else if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      return 1'b0;
    end
    size = 1 << f3[1:0];
    return (int'(a) % size) == 0;
  endfunction

  function automatic logic [31:0] ld_ref(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(a))) & 32'hFF;
    h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic run_op(input bit w, input bit r, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [4:0] rd, input bit rwen,
                        input int lat, input logic [31:0] rw);
    int size;
    int n;
    logic [31:0] exp_be;
    logic [31:0] exp_wd;
    logic [31:0] nx_alu;
    logic [4:0]  nx_rd;
    bit          nx_wen;
    in_valid = 1'b1; alu_result = addr; store_data = sd; rd_in = rd;
    reg_wen_in = rwen; mem_wen_in = w; mem_ren_in = r; funct3 = f3;
    @(posedge clk); #1;
    if (!(w | r)) begin
      chk("alu_wbv", wb_valid, 1); chk("alu_data", wb_data, addr);
      chk("alu_rd", wb_rd, rd); chk("alu_wen", wb_reg_wen, rwen);
      chk("alu_req", u_if.dmem_req, 0); chk("alu_flt", mem_fault, 0);
      exp_data = addr; data_known = 1'b1;
    end else if (!legal_ref(w, f3, addr[1:0])) begin
      chk("ill_wbv", wb_valid, 1); chk("ill_wen", wb_reg_wen, 0);
      chk("ill_data", wb_data, 0); chk("ill_flt", mem_fault, 1);
      chk("ill_req", u_if.dmem_req, 0); chk("ill_stall", stall_out, 0);
      exp_data = 32'd0; data_known = 1'b1;
    end else begin
      size   = w ? (1 << f3[1:0]) : 4;
      exp_be = ((32'd1 << size) - 1) << (w ? int'(addr[1:0]) : 0);
      exp_wd = (size == 1) ? sd[7:0] * 32'h0101_0101 :
               (size == 2) ? sd[15:0] * 32'h0001_0001 : sd;
      chk("cap_wbv", wb_valid, 0);
      // Next instruction is presented while BUSY and must be held off.
      nx_alu = $urandom; nx_rd = 5'($urandom); nx_wen = 1'($urandom);
      alu_result = nx_alu; rd_in = nx_rd; reg_wen_in = nx_wen;
      mem_wen_in = 1'b0; mem_ren_in = 1'b0;
      n = 0;
      for (int k = 0; k < 64; k++) begin
        chk("busy_req", u_if.dmem_req, 1); chk("busy_stall", stall_out, 1);
        chk("busy_wbv", wb_valid, 0); chk("busy_we", u_if.dmem_we, w);
        chk("busy_addr", u_if.dmem_addr, addr & 32'hFFFF_FFFC);
        chk("busy_be", u_if.dmem_be, exp_be);
        if (w) chk("busy_wdata", u_if.dmem_wdata, exp_wd);
        n++;
        u_if.dmem_ready = (k == lat); u_if.dmem_rdata = rw;
        @(posedge clk); #1;
        u_if.dmem_ready = 1'b0;
        if (k == lat) begin
          chk("done_wbv", wb_valid, 1); chk("done_rd", wb_rd, rd);
          chk("done_flt", mem_fault, 0);
          chk("done_wen", wb_reg_wen, w ? 1'b0 : rwen);
          exp_data = w ? 32'd0 : ld_ref(rw, f3, addr[1:0]);
          chk("done_data", wb_data, exp_data); data_known = 1'b1;
          break;
        end
        if (k == MAXW - 1) begin
          chk("to_wbv", wb_valid, 1); chk("to_wen", wb_reg_wen, 0);
          chk("to_flt", mem_fault, 1); data_known = 1'b0;
          break;
        end
      end
      chk("req_cycles", n, (lat < MAXW) ? lat + 1 : MAXW);
      chk("post_req", u_if.dmem_req, 0); chk("post_stall", stall_out, 0);
      @(posedge clk); #1;
      chk("nx_wbv", wb_valid, 1); chk("nx_data", wb_data, nx_alu);
      chk("nx_rd", wb_rd, nx_rd); chk("nx_wen", wb_reg_wen, nx_wen);
      exp_data = nx_alu; data_known = 1'b1;
    end
    in_valid = 1'b0; mem_wen_in = 1'b0; mem_ren_in = 1'b0;
    @(posedge clk); #1;
    chk("idle_wbv", wb_valid, 0); chk("idle_flt", mem_fault, 0);
    if (data_known) chk("idle_hold", wb_data, exp_data);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", u_if.dmem_req, 0); chk("rst_stall", stall_out, 0);
    chk("rst_wbv", wb_valid, 0); chk("rst_data", wb_data, 0);
    chk("rst_flt", mem_fault, 0); chk("rst_wen", wb_reg_wen, 0);
    reset = 1'b0;

    // Directed cases.
    run_op(0, 0, 3'd0, 32'h1234_5678, 32'd0, 5'd5, 1, 0, 32'd0);
    run_op(1, 0, 3'd0, 32'h0000_0103, 32'hAB, 5'd3, 1, 0, 32'd0);
    run_op(0, 1, 3'd0, 32'h0000_0102, 32'd0, 5'd7, 1, 0, 32'h80FF_7F01);
    run_op(0, 1, 3'd5, 32'h0000_0102, 32'd0, 5'd8, 1, 0, 32'h80FF_7F01);
    run_op(0, 1, 3'd2, 32'h0000_0200, 32'd0, 5'd9, 1, 3, 32'hCAFE_F00D);
    run_op(0, 1, 3'd2, 32'h0000_0102, 32'd0, 5'd9, 1, 0, 32'd0);
    run_op(0, 1, 3'd2, 32'h0000_0300, 32'd0, 5'd10, 1, 99, 32'd0);
    run_op(1, 1, 3'd1, 32'h0000_0402, 32'h5A5A_1234, 5'd11, 1, 1, 32'd0);

    // Reset while BUSY abandons the access.
    in_valid = 1'b1; mem_ren_in = 1'b1; funct3 = 3'd2; alu_result = 32'h400; rd_in = 5'd4;
    @(posedge clk); #1;
    chk("mid_req", u_if.dmem_req, 1);
    in_valid = 1'b0; mem_ren_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_req", u_if.dmem_req, 0); chk("mid_rst_stall", stall_out, 0);
    chk("mid_rst_wbv", wb_valid, 0);
    reset = 1'b0; exp_data = 32'd0; data_known = 1'b1;
    run_op(0, 1, 3'd2, 32'h0000_0500, 32'd0, 5'd12, 1, 1, 32'h1357_9BDF);

    // Random mix.
    for (int i = 0; i < 200; i++) begin
      int kind;
      int lat;
      kind = $urandom_range(0, 9);
      lat  = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3);
      run_op((kind >= 6), (kind >= 3 && kind != 6) || kind == 9, 3'($urandom),
             $urandom, $urandom, 5'($urandom), 1'($urandom), lat, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline.
- Consumes the registered EX/MEM outputs and drives a request/ready data-memory port.
- Aligns store byte lanes and sign/zero-extends loads.
- Delivers a registered result to the MEM/WB boundary, and stalls upstream while a memory access is outstanding.

Parameters:
MAX_WAIT, 16, maximum cycles dmem_req may stay high without dmem_ready before the access is aborted with a fault (range 1..255)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_valid  input  1  EX/MEM slot holds a real instruction
alu_result  input  32  effective address, or ALU result for non-memory ops
store_data  input  32  rs2 value for stores
rd_in  input  5  destination register
reg_wen_in  input  1  instruction writes rd
mem_wen_in  input  1  store
mem_ren_in  input  1  load
funct3  input  3  access size/sign
dmem_req  output  1  memory request valid
dmem_we  output  1  1=write, 0=read
dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  output  32  lane-aligned store data
dmem_be  output  4  byte enables
dmem_ready  input  1  memory accepts/completes the request this cycle
dmem_rdata  input  32  read word, valid when dmem_ready=1 on a read
stall_out  output  1  upstream must hold its register
wb_valid  output  1  one-cycle result strobe to MEM/WB
wb_rd  output  5  destination register
wb_data  output  32  load result or passed-through alu_result
wb_reg_wen  output  1  register write enable
mem_fault  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
  - All outputs reset to 0. State goes to IDLE and the wait counter to 0.
  - Reset asserted during BUSY drops dmem_req at that edge; the access is discarded with no wb_valid.
- FSM states: IDLE, BUSY.
- IDLE, in_valid=0:
  - wb_valid=0 at the next edge.
- IDLE, in_valid=1, neither mem_wen_in nor mem_ren_in set:
  - Next edge: wb_valid=1, wb_data=alu_result, wb_rd=rd_in, wb_reg_wen=reg_wen_in.
  - Latency 1 cycle.
- IDLE, in_valid=1, memory op, address legal:
  - Capture address, size, sign, rd, reg_wen, we and aligned wdata/be.
  - Go to BUSY. wb_valid=0 at the next edge.
- IDLE, memory op, illegal access. Illegal means any of:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - load funct3 not in {000,001,010,100,101};
  - store funct3 not in {000,001,010}.
  - Response: no request is issued. Next edge: wb_valid=1, wb_reg_wen=0, wb_data=0, mem_fault=1.
- mem_wen_in and mem_ren_in both set: treated as a store.
- BUSY:
  - dmem_req=1. dmem_we, dmem_addr, dmem_wdata and dmem_be are held stable.
  - stall_out=1.
  - Counter increments each cycle that dmem_ready=0.
- BUSY, dmem_ready=1:
  - Next edge returns to IDLE. wb_valid=1, wb_rd is the captured rd.
  - Load: wb_data is the extended lane of dmem_rdata; wb_reg_wen is the captured value.
  - Store: wb_reg_wen=0, wb_data=0.
- BUSY timeout: when the counter reaches MAX_WAIT-1 with dmem_ready=0, the next edge goes to IDLE with wb_valid=1, wb_reg_wen=0, mem_fault=1.
- Upstream protocol:
  - stall_out is 0 in IDLE, so the instruction after a memory op is presented while in BUSY and held.
  - That instruction is accepted in the IDLE cycle after completion.
- Memory latency: minimum 2 cycles (capture, then request with dmem_ready=1).
- Store lane rules, with a = addr[1:0]:
  - SB: be = 1<<a; wdata = {4{sd[7:0]}}.
  - SH: be = 0011 if a[1]=0, else 1100; wdata = {2{sd[15:0]}}.
  - SW: be = 1111; wdata = sd.
- Load rules:
  - Byte = rdata[8a+7:8a]; halfword = rdata[16a[1]+15:16a[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - dmem_be=1111 on reads.
- Strobes: wb_valid and mem_fault are single-cycle pulses. All wb_* outputs hold their value when wb_valid=0.

Decomposition:
- Package mem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum {IDLE, BUSY}.
- One combinational sub-module, lsu_align, does store lane/be generation, load extraction/extension and the legality check; it is unit-testable alone.

Test Plan:
- ALU pass-through: in_valid=1, alu_result=0x1234_5678, rd=5, reg_wen=1 -> next cycle wb_valid=1, wb_data=0x12345678, wb_rd=5; dmem_req never rises.
- SB: addr=0x103, sd=0xAB, ready tied 1 -> dmem_addr=0x100, be=1000, wdata=0xABABABAB, dmem_req high 1 cycle, then wb_valid=1 with wb_reg_wen=0.
- LB at 0x102 and LHU at 0x102, rdata=0x80FF_7F01 -> LB gives wb_data=0xFFFFFFFF; LHU gives 0x000080FF.
- LW, dmem_ready delayed 3 cycles -> stall_out=1 for exactly 4 cycles; the next instruction completes in the cycle after the load's wb_valid.
- LW at 0x102 -> no dmem_req; wb_valid=1, wb_reg_wen=0, mem_fault=1. Separately, MAX_WAIT=4 with ready held 0 -> mem_fault after 4 request cycles.
- Reset asserted mid-BUSY -> dmem_req=0, stall_out=0, wb_valid=0 after that edge; a later LW completes normally.
